// File: rtl/sprite_anim_renderer_if.sv
// ---------------------------------------------------------------------------
// sprite_anim_renderer_if
//
// Memory-side bus of the sprite renderer: the sprite-sheet ROM and the
// colour palette.
//
//   rom_addr : sprite-sheet address, driven from a register by the renderer.
//   rom_q    : 4-bit palette index read from rom_addr. The renderer samples it
//              on the clock edge that follows the edge that produced rom_addr.
//   pal_idx  : palette index, driven from a register by the renderer.
//   pal_rgb  : combinational palette colour for pal_idx, {r[3:0],g[3:0],b[3:0]}.
//
// master : renderer side      slave : ROM / palette side
// ---------------------------------------------------------------------------
interface sprite_anim_renderer_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_q;
    logic [3:0]        pal_idx;
    logic [11:0]       pal_rgb;

    modport master (
        output rom_addr,
        output pal_idx,
        input  rom_q,
        input  pal_rgb
    );

    modport slave (
        input  rom_addr,
        input  pal_idx,
        output rom_q,
        output pal_rgb
    );
endinterface

// File: rtl/sprite_anim_renderer.sv
// ---------------------------------------------------------------------------
// sprite_anim_renderer
//
// Pipelined pixel renderer for one animated fighter sprite. For every screen
// pixel (DrawX, DrawY) it decides whether the pixel falls inside the scaled
// sprite box, fetches the palette index from the sprite-sheet ROM, looks the
// colour up in the external palette and emits RGB plus a draw-enable for the
// layer mixer. Latency from DrawX/DrawY to RGB/draw_en is 3 clocks.
//
// Character, pose and flip are captured only on frame_tick, so a sprite never
// changes look halfway down the screen. Each pose has N_FRAMES animation
// frames advanced every FRAME_DIV video frames; hit_flash starts a blinking
// white flash lasting FLASH_FRAMES video frames.
//
// Ports:
//   vga_clk, reset       pixel clock, asynchronous active-high reset
//   frame_tick           one-cycle pulse at the start of vertical blank
//   blank                1 = active video
//   DrawX, DrawY         current pixel
//   spritex, spritey     sprite top-left corner on screen
//   char_sel, pose_req   character select, requested poses (bit 0 wins)
//   flip                 mirror horizontally
//   hit_flash            one-cycle pulse that (re)starts the flash
//   mem                  ROM/palette bus (see sprite_anim_renderer_if)
//   red, green, blue     registered pixel colour
//   draw_en              1 = opaque sprite pixel this cycle
// ---------------------------------------------------------------------------
module sprite_anim_renderer #(
    parameter int SPR_W        = 64,
    parameter int SPR_H        = 64,
    parameter int SCALE_SH     = 1,
    parameter int N_CHAR       = 4,
    parameter int N_POSE       = 9,
    parameter int N_FRAMES     = 2,
    parameter int FRAME_DIV    = 8,
    parameter int FLASH_FRAMES = 16,
    parameter int KEY_IDX      = 0,
    parameter int ADDR_W       = $clog2(N_CHAR * N_POSE * N_FRAMES * SPR_W * SPR_H),
    localparam int CHAR_W      = (N_CHAR > 1) ? $clog2(N_CHAR) : 1
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                blank,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [9:0]          spritex,
    input  logic [9:0]          spritey,
    input  logic [CHAR_W-1:0]   char_sel,
    input  logic [N_POSE-1:0]   pose_req,
    input  logic                flip,
    input  logic                hit_flash,
    sprite_anim_renderer_if.master mem,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                draw_en
);

    localparam int POSE_W   = (N_POSE > 1) ? $clog2(N_POSE) : 1;
    localparam int FRM_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FL_W_RAW = $clog2(FLASH_FRAMES + 1);
    localparam int FL_W     = (FL_W_RAW < 2) ? 2 : FL_W_RAW;
    localparam int COL_W    = $clog2(SPR_W);
    localparam int ROW_W    = $clog2(SPR_H);

    localparam logic signed [10:0] BOX_W     = 11'(SPR_W << SCALE_SH);
    localparam logic signed [10:0] BOX_H     = 11'(SPR_H << SCALE_SH);
    localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(SPR_W - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FRAME_DIV - 1);
    localparam logic [FRM_W-1:0]   FRM_LAST  = FRM_W'(N_FRAMES - 1);
    localparam logic [FL_W-1:0]    FL_LOAD   = FL_W'(FLASH_FRAMES);
    localparam logic [3:0]         KEY_4     = 4'(KEY_IDX);
    localparam logic [ADDR_W-1:0]  N_POSE_A  = ADDR_W'(N_POSE);
    localparam logic [ADDR_W-1:0]  N_FRM_A   = ADDR_W'(N_FRAMES);
    localparam logic [ADDR_W-1:0]  SPR_SZ_A  = ADDR_W'(SPR_W * SPR_H);

    // Index of the lowest set request bit; bit 0 is the highest-priority pose.
    function automatic logic [POSE_W-1:0] lowest_pose(input logic [N_POSE-1:0] req);
        logic [POSE_W-1:0] idx;
        idx = '0;
        for (int i = N_POSE - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = POSE_W'(i);
            end
        end
        return idx;
    endfunction

    // -----------------------------------------------------------------------
    // Per-video-frame state: latched selection, animation and flash
    // -----------------------------------------------------------------------
    logic [POSE_W-1:0] pose_q;
    logic [CHAR_W-1:0] char_q;
    logic              flip_q;
    logic [FRM_W-1:0]  frame_q;
    logic [DIV_W-1:0]  div_q;
    logic [FL_W-1:0]   flash_q;

    logic [POSE_W-1:0] pose_d;
    logic              anim_restart;
    logic              flash_vis;

    // An all-zero request keeps the previously latched pose.
    assign pose_d       = (pose_req != '0) ? lowest_pose(pose_req) : pose_q;
    assign anim_restart = (pose_d != pose_q) || (char_sel != char_q);
    // Blink: visible in the half of each 4-frame period where bit 1 is set.
    assign flash_vis    = (flash_q != '0) && flash_q[1];

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pose_q  <= '0;
            char_q  <= '0;
            flip_q  <= 1'b0;
            frame_q <= '0;
            div_q   <= '0;
        end else if (frame_tick) begin
            pose_q <= pose_d;
            char_q <= char_sel;
            flip_q <= flip;
            // A new pose or character always starts from its first frame.
            if (anim_restart) begin
                frame_q <= '0;
                div_q   <= '0;
            end else if (div_q == DIV_LAST) begin
                div_q   <= '0;
                frame_q <= (frame_q == FRM_LAST) ? '0 : frame_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // A hit pulse reloads the counter even if a flash is already running and
    // takes precedence over the frame_tick decrement.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            flash_q <= '0;
        end else if (hit_flash) begin
            flash_q <= FL_LOAD;
        end else if (frame_tick && (flash_q != '0)) begin
            flash_q <= flash_q - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 0: geometry (combinational)
    // -----------------------------------------------------------------------
    // 11-bit signed offsets: a pixel left of / above the sprite gives a
    // negative value instead of wrapping to a large in-range one near 1023.
    logic signed [10:0]  dx, dy;
    logic                in_box;
    logic [COL_W-1:0]    col_raw, col;
    logic [ROW_W-1:0]    row;
    logic [ADDR_W-1:0]   slot;
    logic [ADDR_W-1:0]   addr_d;

    assign dx      = signed'({1'b0, DrawX}) - signed'({1'b0, spritex});
    assign dy      = signed'({1'b0, DrawY}) - signed'({1'b0, spritey});
    assign in_box  = !dx[10] && (dx < BOX_W) && !dy[10] && (dy < BOX_H);
    assign col_raw = dx[SCALE_SH +: COL_W];
    assign col     = flip_q ? (COL_LAST - col_raw) : col_raw;
    assign row     = dy[SCALE_SH +: ROW_W];

    // Sheet layout: character-major, then pose, then animation frame; each
    // slot is one SPR_W x SPR_H image stored row-major.
    assign slot   = (ADDR_W'(char_q) * N_POSE_A + ADDR_W'(pose_q)) * N_FRM_A
                    + ADDR_W'(frame_q);
    assign addr_d = slot * SPR_SZ_A + ADDR_W'({row, col});

    // -----------------------------------------------------------------------
    // Pipeline registers
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] rom_addr_q;
    logic              vis_p1_q;
    logic [3:0]        pal_idx_q;
    logic              vis_p2_q;
    logic              draw_en_q;
    logic [11:0]       rgb_q;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_addr_q <= '0;
            vis_p1_q   <= 1'b0;
            pal_idx_q  <= '0;
            vis_p2_q   <= 1'b0;
            draw_en_q  <= 1'b0;
            rgb_q      <= '0;
        end else begin
            // Stage 1: ROM address, parked at 0 outside the sprite box
            rom_addr_q <= in_box ? addr_d : '0;
            vis_p1_q   <= in_box && blank;

            // Stage 2: ROM data becomes the palette index; key colour is transparent
            pal_idx_q <= mem.rom_q;
            vis_p2_q  <= vis_p1_q && (mem.rom_q != KEY_4);

            // Stage 3: palette colour (or flash white) to the mixer
            if (vis_p2_q) begin
                draw_en_q <= 1'b1;
                rgb_q     <= flash_vis ? 12'hFFF : mem.pal_rgb;
            end else begin
                draw_en_q <= 1'b0;
                rgb_q     <= '0;
            end
        end
    end

    assign mem.rom_addr      = rom_addr_q;
    assign mem.pal_idx       = pal_idx_q;
    assign {red, green, blue} = rgb_q;
    assign draw_en           = draw_en_q;

endmodule
